// File: rtl/digital_data_unpacker.sv
// Receive-side word unpacker: serialises deframed words MSB first into the bit FIFO,
// with a one-word holding buffer, per-block bit counting and dropped-word accounting.
module digital_data_unpacker #(
    parameter int WORD_W     = 12,
    parameter int FIFO_DEPTH = 16384,
    parameter int BLOCK_BITS = 10416
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frameStart,
    input  logic              wordStrobe,
    input  logic [WORD_W-1:0] wordData,
    input  logic [14:0]       fifoUsed,
    output logic              bitData,
    output logic              bitWrite,
    output logic              blockDone,
    output logic              overrun,
    output logic [7:0]        dropCount
);
    localparam int               CNT_W       = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WORD_W - 1);
    localparam logic [14:0]      STALL_LEVEL = 15'(FIFO_DEPTH - 1);
    localparam logic [14:0]      BLOCK_LAST  = 15'(BLOCK_BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [2:0]        ws_sync, fs_sync;
    logic              ws_front, fs_front;
    logic [WORD_W-1:0] hold;
    logic              hold_valid;
    logic              consume, drop;

    state_t            state, state_n;
    logic              phase, phase_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [WORD_W-1:0] shreg, shreg_n;
    logic              bit_data_n, bit_write_n;
    logic [14:0]       bits_written;

    // Strobe and frame marker come from slower logic; three flops settle and edge-detect them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws_sync <= '0;
            fs_sync <= '0;
        end else begin
            ws_sync <= {ws_sync[1:0], wordStrobe};
            fs_sync <= {fs_sync[1:0], frameStart};
        end
    end

    assign ws_front = ws_sync[1] & ~ws_sync[2];
    assign fs_front = fs_sync[1] & ~fs_sync[2];

    // A hold slot being drained by the shifter this cycle is free for the arriving word.
    assign drop = ws_front & hold_valid & ~consume;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            overrun    <= 1'b0;
            dropCount  <= '0;
        end else begin
            if (ws_front && !drop) begin
                hold       <= wordData;
                hold_valid <= 1'b1;
            end else if (consume) begin
                hold_valid <= 1'b0;
            end

            if (drop)
                overrun <= 1'b1;
            else if (fs_front)
                overrun <= 1'b0;

            if (drop && dropCount != 8'hFF)
                dropCount <= dropCount + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            bitData  <= 1'b0;
            bitWrite <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            bitData  <= bit_data_n;
            bitWrite <= bit_write_n;
        end
    end

    // Each bit takes two cycles: present it with a write pulse, then advance the shifter.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        bit_data_n  = bitData;
        bit_write_n = 1'b0;
        consume     = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_valid) begin
                    consume   = 1'b1;
                    shreg_n   = hold;
                    bit_cnt_n = '0;
                    phase_n   = 1'b0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (!phase) begin
                    if (fifoUsed < STALL_LEVEL) begin
                        bit_data_n  = shreg[WORD_W-1];
                        bit_write_n = 1'b1;
                        phase_n     = 1'b1;
                    end
                end else begin
                    shreg_n   = shreg << 1;
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                    phase_n   = 1'b0;
                    if (bit_cnt == LAST_BIT)
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A frame marker restarts block counting and beats a same-cycle write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bits_written <= '0;
            blockDone    <= 1'b0;
        end else begin
            blockDone <= 1'b0;
            if (fs_front) begin
                bits_written <= '0;
            end else if (bitWrite) begin
                if (bits_written == BLOCK_LAST) begin
                    bits_written <= '0;
                    blockDone    <= 1'b1;
                end else begin
                    bits_written <= bits_written + 15'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_digital_data_unpacker.sv
// Randomised bench for digital_data_unpacker: a word-queue scoreboard predicts the bit
// stream, drop accounting and block pulses; literal checks pin the model on known cases.
module tb_digital_data_unpacker;
    localparam int BLOCK_BITS = 10416;
    localparam int STALL      = 16383;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frameStart = 1'b0;
    logic        wordStrobe = 1'b0;
    logic [11:0] wordData = '0;
    logic [14:0] fifoUsed = '0;
    logic        bitData, bitWrite, blockDone, overrun;
    logic [7:0]  dropCount;

    digital_data_unpacker #(.WORD_W(12), .FIFO_DEPTH(16384), .BLOCK_BITS(BLOCK_BITS)) dut (
        .clk(clk), .reset(reset), .frameStart(frameStart), .wordStrobe(wordStrobe),
        .wordData(wordData), .fifoUsed(fifoUsed), .bitData(bitData), .bitWrite(bitWrite),
        .blockDone(blockDone), .overrun(overrun), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fifo_prev = 0;
    int fifo_mode = 0;

    // Scoreboard state: bits still owed by the DUT, drop/overrun and block expectations.
    bit exp_q[$];
    bit exp_ovr = 0;
    int exp_drop = 0;
    int blk = 0;
    bit exp_bd = 0;
    bit prev_bw = 0;
    int cap_cyc = -1;
    bit cap_drop = 0;
    int fs_cyc = -1;
    bit obs_bits[$];
    int obs_cyc[$];
    int bd_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        fifo_prev = int'(fifoUsed);
    end

    always @(posedge clk) begin
        #1;
        case (fifo_mode)
            0: fifoUsed = 15'd0;
            2: fifoUsed = 15'(STALL);
            default: begin
                case ($urandom_range(0, 15))
                    0: fifoUsed = 15'(STALL);
                    1: fifoUsed = 15'(STALL - 1);
                    2: fifoUsed = 15'($urandom_range(16384, 32767));
                    default: fifoUsed = 15'($urandom_range(0, 16381));
                endcase
            end
        endcase
    end

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            exp_ovr  = 0;
            exp_drop = 0;
            blk      = 0;
            exp_bd   = 0;
            prev_bw  = 0;
        end else begin
            if (cyc == cap_cyc && cap_drop) begin
                exp_ovr = 1;
                if (exp_drop < 255) exp_drop++;
            end
            if (cyc == fs_cyc) exp_ovr = 0;
            check("overrun", overrun, exp_ovr);
            check("dropCount", dropCount, exp_drop);
            check("blockDone", blockDone, exp_bd);
            if (blockDone) bd_seen++;
            if (bitWrite) begin
                check("bitWrite_width", prev_bw, 0);
                check("write_while_full", (fifo_prev >= STALL) ? 1 : 0, 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bitData_unexpected: got write of %0d, expected no write (cycle %0d)", bitData, cyc);
                end else begin
                    check("bitData", bitData, exp_q.pop_front());
                end
                obs_bits.push_back(bitData);
                obs_cyc.push_back(cyc);
            end
            exp_bd = 0;
            if (fs_cyc == cyc + 1) begin
                blk = 0;
            end else if (bitWrite) begin
                blk++;
                if (blk == BLOCK_BITS) begin
                    blk = 0;
                    exp_bd = 1;
                end
            end
            prev_bw = bitWrite;
        end
    end

    // Waits only while the acceptance outcome would hinge on a cycle-exact race.
    task automatic send_word(input logic [11:0] d, output bit acc);
        int guard = 0;
        int owned, rem;
        forever begin
            owned = (exp_q.size() + 11) / 12;
            rem   = exp_q.size() - 12 * (owned - 1);
            if (owned <= 1 || rem >= 4) break;
            @(posedge clk); #1;
            guard++;
            if (guard > 400) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got %0d bits pending, expected drain (cycle %0d)", exp_q.size(), cyc);
                acc = 0;
                return;
            end
        end
        acc = (owned <= 1);
        if (acc)
            for (int i = 11; i >= 0; i--) exp_q.push_back(d[i]);
        cap_cyc    = cyc + 3;
        cap_drop   = !acc;
        wordData   = d;
        wordStrobe = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        wordStrobe = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic frame_edge();
        fs_cyc     = cyc + 3;
        frameStart = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        frameStart = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin @(posedge clk); #1; n++; end
        check("drain_pending", exp_q.size(), 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic wait_bits(input int base, input int nbits);
        int n = 0;
        while (obs_bits.size() - base < nbits && n < 200) begin @(posedge clk); #1; n++; end
        check("wait_bits", (obs_bits.size() - base >= nbits) ? 1 : 0, 1);
    endtask

    initial begin
        int exp1 [12];
        int base, c0, n0, accepted, taken, guard;
        bit acc;
        exp1 = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0};

        repeat (3) begin @(posedge clk); #1; end
        check("rst_bitWrite", bitWrite, 0);
        check("rst_bitData", bitData, 0);
        check("rst_blockDone", blockDone, 0);
        check("rst_overrun", overrun, 0);
        check("rst_dropCount", dropCount, 0);
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // Single word 0xA5C: bit order, first-write latency and span.
        base = obs_bits.size();
        c0   = cyc;
        send_word(12'hA5C, acc);
        drain(200);
        check("t1_count", obs_bits.size() - base, 12);
        if (obs_bits.size() - base >= 12) begin
            for (int i = 0; i < 12; i++) check("t1_bit", obs_bits[base + i], exp1[i]);
            check("t1_latency", obs_cyc[base] - c0, 5);
            check("t1_span", obs_cyc[base + 11] - obs_cyc[base], 22);
        end

        // Three words 4 clk apart: third is dropped.
        base = obs_bits.size();
        send_word(12'hFFF, acc);
        send_word(12'h000, acc);
        send_word(12'h123, acc);
        check("t2_third_accepted", acc, 0);
        drain(400);
        check("t2_count", obs_bits.size() - base, 24);
        check("t2_overrun", overrun, 1);
        check("t2_dropCount", dropCount, 1);
        frame_edge();
        check("t2_overrun_cleared", overrun, 0);
        check("t2_dropCount_kept", dropCount, 1);

        // Stall for 40 clk mid-word.
        base = obs_bits.size();
        send_word(12'h3C6, acc);
        wait_bits(base, 5);
        fifo_mode = 2;
        repeat (3) begin @(posedge clk); #1; end
        n0 = obs_bits.size();
        repeat (37) begin @(posedge clk); #1; end
        check("t3_writes_in_stall", obs_bits.size() - n0, 0);
        fifo_mode = 0;
        drain(200);
        check("t3_count", obs_bits.size() - base, 12);

        // 868 accepted words with random data, gaps and FIFO level: one full block.
        frame_edge();
        c0 = bd_seen;
        base = obs_bits.size();
        fifo_mode = 1;
        accepted = 0;
        guard = 0;
        while (accepted < 868 && guard < 4000) begin
            send_word(12'($urandom), acc);
            if (acc) accepted++;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            guard++;
        end
        fifo_mode = 0;
        drain(3000);
        repeat (4) begin @(posedge clk); #1; end
        check("t4_accepted", accepted, 868);
        check("t4_bits", obs_bits.size() - base, BLOCK_BITS);
        check("t4_blockDone_pulses", bd_seen - c0, 1);

        // Reset in mid-word, then a fresh word.
        base = obs_bits.size();
        send_word(12'hD2B, acc);
        wait_bits(base, 5);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("t5_bitWrite", bitWrite, 0);
        check("t5_bitData", bitData, 0);
        check("t5_blockDone", blockDone, 0);
        check("t5_overrun", overrun, 0);
        check("t5_dropCount", dropCount, 0);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("t5_no_writes_after_reset", obs_bits.size() - base, 5);
        base = obs_bits.size();
        send_word(12'h9B4, acc);
        drain(200);
        check("t5_count", obs_bits.size() - base, 12);
        if (obs_bits.size() - base >= 12) begin
            check("t5_first_bit", obs_bits[base], 1);
            check("t5_last_bit", obs_bits[base + 11], 0);
        end

        // 300 drops while stalled: counter saturates.
        send_word(12'h5A5, acc);
        send_word(12'h0F0, acc);
        fifo_mode = 2;
        taken = 0;
        for (int i = 0; i < 300; i++) begin
            send_word(12'($urandom), acc);
            if (acc) taken++;
        end
        check("t6_taken", taken, 0);
        check("t6_dropCount", dropCount, 255);
        check("t6_overrun", overrun, 1);
        fifo_mode = 0;
        drain(400);
        frame_edge();
        check("t6_overrun_cleared", overrun, 0);
        check("t6_dropCount_kept", dropCount, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        fails++;
        $display("FAIL watchdog: got no completion, expected finish before cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
